shift_unit_arbiter: RTL and testbench
=====================================

// Module: shift_unit_arbiter
// PURPOSE
//  Shares one N-bit shift datapath between NUM_REQ requesters, such as the ALU
//  and an address-generation path. The datapath is the team's SLL, SRL and SRA
//  barrel shifters plus an op mux. A round-robin arbiter grants one request per
//  cycle. The result goes into a single-entry output register with a
//  valid/ready handshake, which gives 1-cycle latency and full throughput.
// PARAMETERS
//  N        32  data width; shamt width is $clog2(N)
//  NUM_REQ  2   number of requesters (>=2); ID width is $clog2(NUM_REQ)
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  asynchronous, active-high reset
//  req_valid  in   NUM_REQ            request i presents an operation
//  req_ready  out  NUM_REQ            request i accepted this cycle (one-hot or 0)
//  req_in     in   NUM_REQ*N          operand; slice i = [i*N +: N]
//  req_shamt  in   NUM_REQ*$clog2(N)  shift amount, slice i
//  req_op     in   NUM_REQ*2          op, slice i: 00 SLL, 01 SRL, 11 SRA, 10 PASS
//  rsp_valid  out  1                  output register holds a result
//  rsp_ready  in   1                  consumer takes result this cycle
//  rsp_out    out  N                  shifted result
//  rsp_id     out  $clog2(NUM_REQ)    index of the requester that owns rsp_out
// BEHAVIOUR
//  - Reset (async, immediate): rsp_valid=0, rsp_out=0, rsp_id=0, state=EMPTY,
//    last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
//  - States:
//    - EMPTY: rsp_valid=0.
//    - FULL: rsp_valid=1.
//  - can_accept = (state==EMPTY) | (rsp_valid & rsp_ready). This allows a
//    drain and a refill in the same cycle.
//  - Grant (combinational):
//    - Search req_valid starting at index last_grant+1, wrapping modulo NUM_REQ.
//      The first set bit wins.
//    - req_ready[i] = can_accept & (winner==i). With no req_valid, req_ready=0.
//    - req_ready may depend on req_valid. req_valid must never depend on
//      req_ready.
//  - Accept at the posedge where req_valid[i] & req_ready[i]:
//    - rsp_out <= op(req_in_i, req_shamt_i); rsp_id <= i; rsp_valid <= 1.
//    - last_grant <= i; state -> FULL.
//  - FULL & rsp_ready & no accept: rsp_valid <= 0, state -> EMPTY. rsp_out and
//    rsp_id keep their last values.
//  - FULL & !rsp_ready: rsp_out and rsp_id are held stable, and req_ready=0.
//  - Ops:
//    - SLL zero-fills from the LSB. SRL zero-fills from the MSB.
//    - SRA replicates in[N-1].
//    - PASS returns in unchanged. shamt is ignored.
//    - shamt=0 returns in for every op.
//  - Latency: 1 cycle from accept to rsp_valid.
//  - Throughput: 1 result per cycle while rsp_ready=1.
//  - Fairness: a continuously valid requester waits at most NUM_REQ-1 accepts.
//  - Requesters hold valid and payload stable until accepted. Ungranted payloads
//    are ignored.
//  - rst mid-operation: the held result is discarded and is not re-issued.
//    Requesters re-present after rst deasserts.
//  - Only last_grant, state, rsp_valid, rsp_out and rsp_id are registered.
//  - The shifters and the op mux are purely combinational on the granted slice.
// TESTING
//  1. Req0 only: in=0x8000_0000, shamt=4, op=SRA, rsp_ready=1.
//     -> Next cycle: rsp_valid=1, rsp_out=0xF800_0000, rsp_id=0.
//  2. Both requesters valid, rsp_ready=1 for 6 cycles.
//     -> rsp_id sequence is 0,1,0,1,0,1, with rsp_valid high every cycle after
//        the first.
//  3. FULL with rsp_ready=0 for 3 cycles.
//     -> req_ready=00 and rsp_out/rsp_id stable.
//     -> On the cycle rsp_ready=1, a new accept occurs and rsp_valid stays 1.
//  4. Op corners:
//     -> SRL 0x8000_0000 by 31 = 0x0000_0001.
//     -> SLL 0x0000_0001 by 31 = 0x8000_0000.
//     -> SRA 0x7FFF_FFFF by 31 = 0x0.
//     -> PASS 0xDEAD_BEEF with shamt=7 = 0xDEAD_BEEF.
//     -> Any op with shamt=0 returns in.
//  5. Assert rst while FULL.
//     -> rsp_valid=0 before the next edge.
//     -> After release, with both valid, rsp_id=0 is granted first.
//  6. Req1 is valid alone for 3 accepts, then req0 joins.
//     -> The next grant goes to req0, since last_grant=1.

Source files
------------

// File: rtl/shift_unit_arbiter.sv
// Shared shift datapath: a round-robin arbiter picks one of NUM_REQ requesters,
// its operand goes through SLL/SRL/SRA/PASS, and the result lands in a
// single-entry output register drained with a valid/ready handshake.
module shift_unit_arbiter #(
    parameter  int N       = 32,
    parameter  int NUM_REQ = 2,
    localparam int SW      = $clog2(N),
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*N-1:0]   req_in_i,
    input  logic [NUM_REQ*SW-1:0]  req_shamt_i,
    input  logic [NUM_REQ*2-1:0]   req_op_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [N-1:0]           rsp_out_o,
    output logic [IDW-1:0]         rsp_id_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b11;

    state_e         state_q, state_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_out_q, rsp_out_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic           found;
    logic [IDW-1:0] winner;
    logic           can_accept;
    logic           accept;
    logic [N-1:0]   sel_in;
    logic [SW-1:0]  sel_shamt;
    logic [1:0]     sel_op;
    logic [N-1:0]   shift_res;

    // Round-robin search: start just after the last winner and take the first valid request.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid_i[(int'(last_grant_q) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = IDW'((int'(last_grant_q) + k) % NUM_REQ);
            end
        end
    end

    // The register can take a new result when empty or when it is being drained this cycle.
    assign can_accept  = (state_q == EMPTY) | (rsp_valid_q & rsp_ready_i);
    assign accept      = can_accept & found;
    assign req_ready_o = accept ? (NUM_REQ'(1) << winner) : '0;

    assign sel_in    = req_in_i[int'(winner)*N +: N];
    assign sel_shamt = req_shamt_i[int'(winner)*SW +: SW];
    assign sel_op    = req_op_i[int'(winner)*2 +: 2];

    // Shifters and op mux on the granted slice; PASS (and any shamt of 0) returns the operand.
    always_comb begin
        shift_res = sel_in;
        case (sel_op)
            OP_SLL:  shift_res = sel_in << sel_shamt;
            OP_SRL:  shift_res = sel_in >> sel_shamt;
            OP_SRA:  shift_res = N'($signed(sel_in) >>> sel_shamt);
            default: shift_res = sel_in;
        endcase
    end

    // Next-state logic: an accept always refills, otherwise a drain empties the register.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_out_d    = rsp_out_q;
        rsp_id_d     = rsp_id_q;
        if (accept) begin
            state_d      = FULL;
            last_grant_d = winner;
            rsp_valid_d  = 1'b1;
            rsp_out_d    = shift_res;
            rsp_id_d     = winner;
        end else if ((state_q == FULL) && rsp_ready_i) begin
            state_d     = EMPTY;
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; reset hands top priority to requester 0 and discards any held result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= EMPTY;
            last_grant_q <= IDW'(NUM_REQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_out_q    <= '0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_out_q    <= rsp_out_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_out_o   = rsp_out_q;
    assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed testbench for shift_unit_arbiter with N=32, NUM_REQ=2.
module tb_shift_unit_arbiter;

    localparam int N       = 32;
    localparam int NUM_REQ = 2;
    localparam int SW      = 5;

    localparam logic [1:0] SLL  = 2'b00;
    localparam logic [1:0] SRL  = 2'b01;
    localparam logic [1:0] SRA  = 2'b11;
    localparam logic [1:0] PASS = 2'b10;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    reqValid;
    logic [NUM_REQ-1:0]    reqReady;
    logic [NUM_REQ*N-1:0]  reqIn;
    logic [NUM_REQ*SW-1:0] reqShamt;
    logic [NUM_REQ*2-1:0]  reqOp;
    logic                  rspValid;
    logic                  rspReady;
    logic [N-1:0]          rspOut;
    logic                  rspId;

    int checksTotal  = 0;
    int checksPassed = 0;

    shift_unit_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .req_in_i    (reqIn),
        .req_shamt_i (reqShamt),
        .req_op_i    (reqOp),
        .rsp_valid_o (rspValid),
        .rsp_ready_i (rspReady),
        .rsp_out_o   (rspOut),
        .rsp_id_o    (rspId)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck run still reports instead of hanging.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d passed", checksPassed, checksTotal);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] d,
                           input logic [4:0] s, input logic [1:0] op);
        reqValid[i]          = v;
        reqIn[i*N +: N]      = d;
        reqShamt[i*SW +: SW] = s;
        reqOp[i*2 +: 2]      = op;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        reqValid = '0;
        reqIn    = '0;
        reqShamt = '0;
        reqOp    = '0;
        rspReady = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        checksTotal++;
        if (rspValid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", rspValid);
        else checksPassed++;
        checksTotal++;
        if (rspOut !== 32'h0) $display("[TB] FAIL reset_out: got %h expected 00000000", rspOut);
        else checksPassed++;
        checksTotal++;
        if (rspId !== 1'b0) $display("[TB] FAIL reset_id: got %b expected 0", rspId);
        else checksPassed++;
        checksTotal++;
        if (reqReady !== 2'b00) $display("[TB] FAIL reset_ready_idle: got %b expected 00", reqReady);
        else checksPassed++;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single_sra();
        do_reset();
        rspReady = 1'b1;
        set_req(0, 1'b1, 32'h8000_0000, 5'd4, SRA);
        #1;
        checksTotal++;
        if (reqReady !== 2'b01) $display("[TB] FAIL single_ready: got %b expected 01", reqReady);
        else checksPassed++;
        tick();
        set_req(0, 1'b0, 32'h0, 5'd0, SLL);
        checksTotal++;
        if (rspValid !== 1'b1 || rspOut !== 32'hF800_0000 || rspId !== 1'b0)
            $display("[TB] FAIL single_sra: got v=%b out=%h id=%b expected v=1 out=f8000000 id=0",
                     rspValid, rspOut, rspId);
        else checksPassed++;
        tick();
        checksTotal++;
        if (rspValid !== 1'b0) $display("[TB] FAIL single_drain: got %b expected 0", rspValid);
        else checksPassed++;
    endtask

    task automatic test_round_robin();
        logic [31:0] expOut;
        do_reset();
        rspReady = 1'b1;
        set_req(0, 1'b1, 32'h0000_0001, 5'd1, SLL);
        set_req(1, 1'b1, 32'h0000_0100, 5'd4, SRL);
        for (int k = 0; k < 6; k++) begin
            tick();
            expOut = (k % 2 == 0) ? 32'h0000_0002 : 32'h0000_0010;
            checksTotal++;
            if (rspValid !== 1'b1 || rspId !== 1'(k % 2) || rspOut !== expOut)
                $display("[TB] FAIL round_robin_%0d: got v=%b id=%b out=%h expected v=1 id=%0d out=%h",
                         k, rspValid, rspId, rspOut, k % 2, expOut);
            else checksPassed++;
        end
        reqValid = '0;
        tick();
    endtask

    task automatic test_back_pressure();
        do_reset();
        rspReady = 1'b0;
        set_req(0, 1'b1, 32'hA5A5_A5A5, 5'd3, PASS);
        tick();
        set_req(0, 1'b0, 32'h0, 5'd0, SLL);
        set_req(1, 1'b1, 32'h0000_00F0, 5'd4, SLL);
        for (int k = 0; k < 3; k++) begin
            #1;
            checksTotal++;
            if (reqReady !== 2'b00 || rspValid !== 1'b1 || rspOut !== 32'hA5A5_A5A5 || rspId !== 1'b0)
                $display("[TB] FAIL stall_%0d: got ready=%b v=%b out=%h id=%b expected ready=00 v=1 out=a5a5a5a5 id=0",
                         k, reqReady, rspValid, rspOut, rspId);
            else checksPassed++;
            tick();
        end
        rspReady = 1'b1;
        #1;
        checksTotal++;
        if (reqReady !== 2'b10) $display("[TB] FAIL stall_release_ready: got %b expected 10", reqReady);
        else checksPassed++;
        tick();
        reqValid = '0;
        checksTotal++;
        if (rspValid !== 1'b1 || rspOut !== 32'h0000_0F00 || rspId !== 1'b1)
            $display("[TB] FAIL stall_refill: got v=%b out=%h id=%b expected v=1 out=00000f00 id=1",
                     rspValid, rspOut, rspId);
        else checksPassed++;
        tick();
    endtask

    task automatic test_ops();
        logic [31:0] vecIn   [11];
        logic [4:0]  vecSh   [11];
        logic [1:0]  vecOp   [11];
        logic [31:0] vecExp  [11];
        vecIn[0]  = 32'h8000_0000; vecSh[0]  = 5'd31; vecOp[0]  = SRL;  vecExp[0]  = 32'h0000_0001;
        vecIn[1]  = 32'h0000_0001; vecSh[1]  = 5'd31; vecOp[1]  = SLL;  vecExp[1]  = 32'h8000_0000;
        vecIn[2]  = 32'h7FFF_FFFF; vecSh[2]  = 5'd31; vecOp[2]  = SRA;  vecExp[2]  = 32'h0000_0000;
        vecIn[3]  = 32'hDEAD_BEEF; vecSh[3]  = 5'd7;  vecOp[3]  = PASS; vecExp[3]  = 32'hDEAD_BEEF;
        vecIn[4]  = 32'h8000_0000; vecSh[4]  = 5'd31; vecOp[4]  = SRA;  vecExp[4]  = 32'hFFFF_FFFF;
        vecIn[5]  = 32'hF000_0000; vecSh[5]  = 5'd4;  vecOp[5]  = SRL;  vecExp[5]  = 32'h0F00_0000;
        vecIn[6]  = 32'hF000_0000; vecSh[6]  = 5'd4;  vecOp[6]  = SRA;  vecExp[6]  = 32'hFF00_0000;
        vecIn[7]  = 32'h1234_5678; vecSh[7]  = 5'd0;  vecOp[7]  = SLL;  vecExp[7]  = 32'h1234_5678;
        vecIn[8]  = 32'h1234_5678; vecSh[8]  = 5'd0;  vecOp[8]  = SRL;  vecExp[8]  = 32'h1234_5678;
        vecIn[9]  = 32'h8765_4321; vecSh[9]  = 5'd0;  vecOp[9]  = SRA;  vecExp[9]  = 32'h8765_4321;
        vecIn[10] = 32'h8765_4321; vecSh[10] = 5'd0;  vecOp[10] = PASS; vecExp[10] = 32'h8765_4321;
        do_reset();
        rspReady = 1'b1;
        for (int k = 0; k < 11; k++) begin
            set_req(0, 1'b1, vecIn[k], vecSh[k], vecOp[k]);
            tick();
            checksTotal++;
            if (rspValid !== 1'b1 || rspOut !== vecExp[k])
                $display("[TB] FAIL op_vec_%0d: got v=%b out=%h expected v=1 out=%h",
                         k, rspValid, rspOut, vecExp[k]);
            else checksPassed++;
        end
        reqValid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rspReady = 1'b0;
        set_req(1, 1'b1, 32'h0000_00FF, 5'd8, SLL);
        tick();
        reqValid = '0;
        checksTotal++;
        if (rspValid !== 1'b1 || rspId !== 1'b1)
            $display("[TB] FAIL mid_fill: got v=%b id=%b expected v=1 id=1", rspValid, rspId);
        else checksPassed++;
        #2;
        rst = 1'b1;
        #1;
        checksTotal++;
        if (rspValid !== 1'b0 || rspOut !== 32'h0)
            $display("[TB] FAIL mid_reset: got v=%b out=%h expected v=0 out=00000000", rspValid, rspOut);
        else checksPassed++;
        tick();
        rst = 1'b0;
        rspReady = 1'b1;
        set_req(0, 1'b1, 32'h0000_0003, 5'd2, SLL);
        set_req(1, 1'b1, 32'h0000_0003, 5'd1, SLL);
        #1;
        checksTotal++;
        if (reqReady !== 2'b01) $display("[TB] FAIL mid_regrant_ready: got %b expected 01", reqReady);
        else checksPassed++;
        tick();
        reqValid = '0;
        checksTotal++;
        if (rspValid !== 1'b1 || rspId !== 1'b0 || rspOut !== 32'h0000_000C)
            $display("[TB] FAIL mid_regrant: got v=%b id=%b out=%h expected v=1 id=0 out=0000000c",
                     rspValid, rspId, rspOut);
        else checksPassed++;
        tick();
    endtask

    task automatic test_fairness();
        do_reset();
        rspReady = 1'b1;
        set_req(1, 1'b1, 32'h0000_0080, 5'd7, SRL);
        for (int k = 0; k < 3; k++) begin
            tick();
            checksTotal++;
            if (rspValid !== 1'b1 || rspId !== 1'b1 || rspOut !== 32'h0000_0001)
                $display("[TB] FAIL solo_req1_%0d: got v=%b id=%b out=%h expected v=1 id=1 out=00000001",
                         k, rspValid, rspId, rspOut);
            else checksPassed++;
        end
        set_req(0, 1'b1, 32'h0000_0005, 5'd3, SLL);
        #1;
        checksTotal++;
        if (reqReady !== 2'b01) $display("[TB] FAIL join_ready: got %b expected 01", reqReady);
        else checksPassed++;
        tick();
        checksTotal++;
        if (rspId !== 1'b0 || rspOut !== 32'h0000_0028)
            $display("[TB] FAIL join_grant: got id=%b out=%h expected id=0 out=00000028", rspId, rspOut);
        else checksPassed++;
        tick();
        reqValid = '0;
        checksTotal++;
        if (rspId !== 1'b1 || rspOut !== 32'h0000_0001)
            $display("[TB] FAIL join_next: got id=%b out=%h expected id=1 out=00000001", rspId, rspOut);
        else checksPassed++;
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        reqValid = '0;
        reqIn    = '0;
        reqShamt = '0;
        reqOp    = '0;
        rspReady = 1'b0;
        test_reset();
        test_single_sra();
        test_round_robin();
        test_back_pressure();
        test_ops();
        test_reset_mid();
        test_fairness();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
